// File: rtl/dic_time_load_ctrl_pkg.sv
// Shared definitions for the display-clock control sequencer.
//   - 3-bit state encodings and the state_t enum built from them
//   - legal upper bound of each digit while it is being loaded
//   - saved-mode encodings (mode to return to when a load ends)
//   - helpers mapping a load state to its digit bound and strobe mask
package dic_time_load_ctrl_pkg;

    localparam logic [2:0] ENC_STOP  = 3'd0;
    localparam logic [2:0] ENC_RUN   = 3'd1;
    localparam logic [2:0] ENC_LD_MT = 3'd2;
    localparam logic [2:0] ENC_LD_MO = 3'd3;
    localparam logic [2:0] ENC_LD_ST = 3'd4;
    localparam logic [2:0] ENC_LD_SO = 3'd5;

    typedef enum logic [2:0] {
        ST_STOP  = ENC_STOP,
        ST_RUN   = ENC_RUN,
        ST_LD_MT = ENC_LD_MT,
        ST_LD_MO = ENC_LD_MO,
        ST_LD_ST = ENC_LD_ST,
        ST_LD_SO = ENC_LD_SO
    } state_t;

    localparam logic [3:0] MT_MAX = 4'd5;
    localparam logic [3:0] MO_MAX = 4'd9;
    localparam logic [3:0] ST_MAX = 4'd5;
    localparam logic [3:0] SO_MAX = 4'd9;

    localparam logic SAVED_STOP = 1'b0;
    localparam logic SAVED_RUN  = 1'b1;

    // Largest digit accepted in a given load state.
    function automatic logic [3:0] digit_max(input state_t s);
        case (s)
            ST_LD_MT: digit_max = MT_MAX;
            ST_LD_MO: digit_max = MO_MAX;
            ST_LD_ST: digit_max = ST_MAX;
            ST_LD_SO: digit_max = SO_MAX;
            default:  digit_max = 4'd0;
        endcase
    endfunction

    // One-hot digit mask {Mtens, Mones, Stens, Sones}; zero outside loads.
    function automatic logic [3:0] ld_mask(input state_t s);
        case (s)
            ST_LD_MT: ld_mask = 4'b1000;
            ST_LD_MO: ld_mask = 4'b0100;
            ST_LD_ST: ld_mask = 4'b0010;
            ST_LD_SO: ld_mask = 4'b0001;
            default:  ld_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dic_timeout_cnt.sv
// Load-timeout second counter.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : synchronous clear (wins over inc)
//   inc       : count one second
//   at_last   : counter sits at TIMEOUT_SEC-1, so the next inc is the timeout;
//               the counter wraps to zero on that inc
module dic_timeout_cnt
    import dic_time_load_ctrl_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_last
);

    logic [CNT_W-1:0] cnt;

    assign at_last = (cnt == CNT_W'(TIMEOUT_SEC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dic_time_load_ctrl.sv
// Run/stop and digit-by-digit time-load sequencer for the mm:ss clock.
//   clk, rst          : clock, asynchronous active-low reset
//   det_cr/S/L/num    : 1-cycle command pulses from the UART detectors
//   det_num_val       : binary digit value, valid with det_num
//   tick_1s           : one-second strobe
//   dicRun            : clock counters advance (RUN only)
//   dicLd*            : registered 1-cycle load strobes, at most one high
//   dicLdValue        : registered load value, held between strobes
//   dicLdErr          : registered pulse on a rejected digit or timeout abort
//   dicDsp*           : per-digit display enables
//   state_dbg         : current FSM state
// Optional build macro DIC_BLINK_EN: blink the digit being entered at 0.5 Hz.
// Command handshake: every det_* input is a single-cycle strobe with no
// back-pressure; it is consumed in the cycle it is high and its effect on
// dicLd*/dicLdValue/dicLdErr appears exactly one cycle later.
module dic_time_load_ctrl
    import dic_time_load_ctrl_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_cr,
    input  logic       det_S,
    input  logic       det_L,
    input  logic       det_num,
    input  logic [3:0] det_num_val,
    input  logic       tick_1s,
    output logic       dicRun,
    output logic       dicLdMtens,
    output logic       dicLdMones,
    output logic       dicLdStens,
    output logic       dicLdSones,
    output logic [3:0] dicLdValue,
    output logic       dicLdErr,
    output logic       dicDspMtens,
    output logic       dicDspMones,
    output logic       dicDspStens,
    output logic       dicDspSones,
    output logic [2:0] state_dbg
);

    state_t     state, state_nxt;
    logic       saved_mode, saved_nxt;
    logic [3:0] ld_q, ld_nxt;
    logic [3:0] val_q;
    logic       val_load;
    logic       err_q, err_nxt;
    logic       cnt_clr, cnt_inc, cnt_last;
    logic       digit_ok;
    state_t     saved_state;
    logic [3:0] dsp;

    assign saved_state = (saved_mode == SAVED_RUN) ? ST_RUN : ST_STOP;
    assign digit_ok    = det_num && (det_num_val <= digit_max(state));

    dic_timeout_cnt #(
        .TIMEOUT_SEC(TIMEOUT_SEC),
        .CNT_W      (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_last(cnt_last)
    );

    always_comb begin
        state_nxt = state;
        saved_nxt = saved_mode;
        ld_nxt    = 4'b0000;
        val_load  = 1'b0;
        err_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_STOP: begin
                if (det_S) begin
                    state_nxt = ST_RUN;
                end else if (det_L) begin
                    state_nxt = ST_LD_MT;
                    saved_nxt = SAVED_STOP;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (det_cr) begin
                    state_nxt = ST_STOP;
                end else if (det_L) begin
                    state_nxt = ST_LD_MT;
                    saved_nxt = SAVED_RUN;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                if (det_cr) begin
                    // Abort quietly; digits already strobed stay loaded.
                    state_nxt = saved_state;
                end else if (digit_ok) begin
                    // An accepted digit restarts the timeout, even on a tick.
                    ld_nxt   = ld_mask(state);
                    val_load = 1'b1;
                    cnt_clr  = 1'b1;
                    case (state)
                        ST_LD_MT: state_nxt = ST_LD_MO;
                        ST_LD_MO: state_nxt = ST_LD_ST;
                        ST_LD_ST: state_nxt = ST_LD_SO;
                        default:  state_nxt = saved_state;
                    endcase
                end else begin
                    err_nxt = det_num;
                    cnt_inc = tick_1s;
                    if (tick_1s && cnt_last) begin
                        state_nxt = saved_state;
                        err_nxt   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_STOP;
            saved_mode <= SAVED_STOP;
            ld_q       <= 4'b0000;
            val_q      <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            saved_mode <= saved_nxt;
            ld_q       <= ld_nxt;
            err_q      <= err_nxt;
            if (val_load) begin
                val_q <= det_num_val;
            end
        end
    end

`ifdef DIC_BLINK_EN
    logic blink;

    // Restarted together with the timeout so each new digit starts blanked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink <= 1'b0;
        end else if (cnt_clr) begin
            blink <= 1'b0;
        end else if (tick_1s && (ld_mask(state) != 4'b0000)) begin
            blink <= ~blink;
        end
    end

    assign dsp = ~(ld_mask(state) & {4{~blink}});
`else
    assign dsp = 4'b1111;
`endif

    assign dicRun      = (state == ST_RUN);
    assign dicLdMtens  = ld_q[3];
    assign dicLdMones  = ld_q[2];
    assign dicLdStens  = ld_q[1];
    assign dicLdSones  = ld_q[0];
    assign dicLdValue  = val_q;
    assign dicLdErr    = err_q;
    assign dicDspMtens = dsp[3];
    assign dicDspMones = dsp[2];
    assign dicDspStens = dsp[1];
    assign dicDspSones = dsp[0];
    assign state_dbg   = state;

endmodule

// File: tb/tb_dic_time_load_ctrl.sv
module tb_dic_time_load_ctrl;

    localparam logic [2:0] E_STOP  = 3'd0;
    localparam logic [2:0] E_RUN   = 3'd1;
    localparam logic [2:0] E_LD_MT = 3'd2;
    localparam logic [2:0] E_LD_MO = 3'd3;
    localparam logic [2:0] E_LD_ST = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       det_cr, det_S, det_L, det_num, tick_1s;
    logic [3:0] det_num_val;
    logic       dicRun, dicLdErr;
    logic       dicLdMtens, dicLdMones, dicLdStens, dicLdSones;
    logic       dicDspMtens, dicDspMones, dicDspStens, dicDspSones;
    logic [3:0] dicLdValue;
    logic [2:0] state_dbg;

    logic [3:0] lds, dsp;
    assign lds = {dicLdMtens, dicLdMones, dicLdStens, dicLdSones};
    assign dsp = {dicDspMtens, dicDspMones, dicDspStens, dicDspSones};

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];   // expected {strobe mask, value} per load strobe

    dic_time_load_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .det_cr     (det_cr),
        .det_S      (det_S),
        .det_L      (det_L),
        .det_num    (det_num),
        .det_num_val(det_num_val),
        .tick_1s    (tick_1s),
        .dicRun     (dicRun),
        .dicLdMtens (dicLdMtens),
        .dicLdMones (dicLdMones),
        .dicLdStens (dicLdStens),
        .dicLdSones (dicLdSones),
        .dicLdValue (dicLdValue),
        .dicLdErr   (dicLdErr),
        .dicDspMtens(dicDspMtens),
        .dicDspMones(dicDspMones),
        .dicDspStens(dicDspStens),
        .dicDspSones(dicDspSones),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && lds != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ld", {24'd0, lds, dicLdValue}, 32'd0);
            end else begin
                check("ld_strobe", {24'd0, lds, dicLdValue}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at negedge+1; holds the inputs for one rising edge and returns
    // at negedge+1, where the registered response is visible.
    task automatic send(input logic cr, input logic s, input logic l,
                        input logic num, input logic [3:0] v, input logic t);
        det_cr = cr; det_S = s; det_L = l; det_num = num; det_num_val = v; tick_1s = t;
        @(negedge clk);
        det_cr = 0; det_S = 0; det_L = 0; det_num = 0; det_num_val = 0; tick_1s = 0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic digit(input logic [3:0] v);
        send(0, 0, 0, 1, v, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 0;
        det_cr = 0; det_S = 0; det_L = 0; det_num = 0; det_num_val = 0; tick_1s = 0;
        idle(2);
        check("rst_state", state_dbg, E_STOP);
        check("rst_run", dicRun, 0);
        check("rst_lds", lds, 0);
        check("rst_val", dicLdValue, 0);
        check("rst_err", dicLdErr, 0);
        check("rst_dsp", dsp, 4'hF);
        rst = 1;
        idle(1);

        // run / stop
        send(0, 1, 0, 0, 0, 0);
        check("s_run", dicRun, 1);
        check("s_dsp", dsp, 4'hF);
        send(1, 0, 0, 0, 0, 0);
        check("cr_stop", dicRun, 0);
        check("cr_dsp", dsp, 4'hF);

        // full load from RUN: 2,3,(6 rejected for Stens),4,9
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0);
        check("ld_frozen", dicRun, 0);
        check("ld_mt_state", state_dbg, E_LD_MT);
        exp_q.push_back({4'b1000, 4'd2});
        digit(2);
        check("mt_lds", lds, 4'b1000);
        check("mt_val", dicLdValue, 2);
        exp_q.push_back({4'b0100, 4'd3});
        digit(3);
        check("mo_lds", lds, 4'b0100);
        check("mo_val", dicLdValue, 3);
        digit(6);
        check("st6_err", dicLdErr, 1);
        check("st6_lds", lds, 0);
        check("st6_state", state_dbg, E_LD_ST);
        exp_q.push_back({4'b0010, 4'd4});
        digit(4);
        check("st_lds", lds, 4'b0010);
        check("st_err", dicLdErr, 0);
        check("st_run", dicRun, 0);
        exp_q.push_back({4'b0001, 4'd9});
        digit(9);
        check("so_lds", lds, 4'b0001);
        check("so_val", dicLdValue, 9);
        check("so_back_run", dicRun, 1);
        idle(1);
        check("so_lds_clear", lds, 0);
        check("val_hold", dicLdValue, 9);
        check("sb_empty1", exp_q.size(), 0);

        // out-of-range Mtens from STOP, then boundary 5
        send(1, 0, 0, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0);
        digit(7);
        check("mt7_err", dicLdErr, 1);
        check("mt7_lds", lds, 0);
        check("mt7_state", state_dbg, E_LD_MT);
        exp_q.push_back({4'b1000, 4'd5});
        digit(5);
        check("mt5_lds", lds, 4'b1000);
        check("mt5_val", dicLdValue, 5);
        check("mt5_err", dicLdErr, 0);
        send(1, 0, 0, 0, 0, 0);
        check("abort_stop", state_dbg, E_STOP);
        check("abort_noerr", dicLdErr, 0);

        // timeout: one digit, then ten ticks
        send(0, 0, 1, 0, 0, 0);
        exp_q.push_back({4'b1000, 4'd1});
        digit(1);
        for (int i = 0; i < 9; i++) begin
            send(0, 0, 0, 0, 0, 1);
        end
        check("to9_state", state_dbg, E_LD_MO);
        check("to9_err", dicLdErr, 0);
        send(0, 0, 0, 0, 0, 1);
        check("to_err", dicLdErr, 1);
        check("to_state", state_dbg, E_STOP);
        check("to_run", dicRun, 0);
        idle(1);
        check("to_err_clear", dicLdErr, 0);

        // abort from RUN with det_cr and det_num together
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0);
        exp_q.push_back({4'b1000, 4'd1});
        digit(1);
        send(1, 0, 0, 1, 4'd3, 0);
        check("crnum_state", state_dbg, E_RUN);
        check("crnum_run", dicRun, 1);
        check("crnum_lds", lds, 0);
        check("crnum_err", dicLdErr, 0);
        check("crnum_val", dicLdValue, 1);
        check("sb_empty2", exp_q.size(), 0);

        // asynchronous reset mid-load, between clock edges
        send(0, 0, 1, 0, 0, 0);
        exp_q.push_back({4'b1000, 4'd4});
        digit(4);
        check("pre_rst_state", state_dbg, E_LD_MO);
        rst = 0;
        #1;
        check("arst_state", state_dbg, E_STOP);
        check("arst_run", dicRun, 0);
        check("arst_val", dicLdValue, 0);
        check("arst_lds", lds, 0);
        check("arst_err", dicLdErr, 0);
        check("arst_dsp", dsp, 4'hF);
        idle(1);
        rst = 1;
        idle(2);
        check("sb_empty3", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dic_time_load_ctrl.md
Name: dic_time_load_ctrl

Overview:
Control-path sequencer for the mm:ss display clock. It extends run/stop control with a digit-by-digit time-load mode driven by UART command detectors. It steers load strobes and a load value into the Mtens/Mones/Stens/Sones counters, and blinks the digit being entered. It sits between the UART command decoders and the clock datapath, alongside the one-second tick generator.

Parameters:
TIMEOUT_SEC, 10, seconds without a digit in any load state before the load aborts (range 1..15)
CNT_W, 4, width of the timeout counter; must hold TIMEOUT_SEC

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
det_cr  input  1  carriage return detected (1-cycle pulse)
det_S  input  1  'S'/'s' detected (1-cycle pulse)
det_L  input  1  'L'/'l' detected (1-cycle pulse)
det_num  input  1  ASCII digit detected (1-cycle pulse)
det_num_val  input  4  binary value of the digit; valid with det_num
tick_1s  input  1  one-second strobe (1-cycle pulse)
dicRun  output  1  clock counters advance
dicLdMtens, dicLdMones, dicLdStens, dicLdSones  output  1 each  load strobes, 1-cycle pulse
dicLdValue  output  4  value to load; valid with any dicLd* strobe
dicLdErr  output  1  1-cycle pulse on a rejected digit or a timeout abort
dicDspMtens, dicDspMones, dicDspStens, dicDspSones  output  1 each  per-digit display enable

Behaviour:
- States: STOP, RUN, LD_MT, LD_MO, LD_ST, LD_SO. A saved-mode register (STOP/RUN) records the mode that was active when the load was entered.
- Reset (rst=0, asynchronous):
  - state=STOP, saved-mode=STOP, timeout counter=0.
  - All dicLd* strobes=0, dicLdValue=0, dicLdErr=0.
  - dicRun=0; all dicDsp*=1.
- Event priority within one cycle: det_cr > det_S > det_L > det_num.
- STOP:
  - det_S -> RUN.
  - det_L -> LD_MT; saved-mode=STOP.
  - det_cr and det_num are ignored.
- RUN:
  - det_cr -> STOP.
  - det_L -> LD_MT; saved-mode=RUN.
  - det_S is ignored.
- Load states, in order LD_MT -> LD_MO -> LD_ST -> LD_SO:
  - Legal ranges: MT 0..5, MO 0..9, ST 0..5, SO 0..9.
  - Legal det_num: the next cycle pulses the matching dicLd* strobe with dicLdValue=det_num_val and advances to the next state.
  - LD_SO with a legal digit returns to saved-mode.
  - Out-of-range det_num: the next cycle pulses dicLdErr; state is unchanged; no strobe.
  - det_cr aborts to saved-mode. Digits already loaded stay loaded; no dicLdErr.
  - det_S and det_L are ignored.
- Timeout:
  - The counter clears on entry to LD_MT and on every accepted digit.
  - It increments on tick_1s while in any load state.
  - On reaching TIMEOUT_SEC: next state = saved-mode, dicLdErr pulses, counter clears.
  - A tick_1s that coincides with an accepted digit clears the counter; it does not increment.
- Outputs:
  - dicRun=1 only in RUN. Counters freeze in every load state.
  - dicRun and dicDsp* are Moore-decoded from the state register.
  - dicLd*, dicLdValue and dicLdErr are registered: 1-cycle latency from the input event.
  - At most one dicLd* is high in any cycle.
  - dicLdValue holds its last value between strobes.

Optional Feature:
DIC_BLINK_EN
- Defined: a blink flop toggles on each tick_1s while in a load state and is cleared on entry to a load state. The enable of the digit being entered equals the blink flop; the other three enables stay 1.
- Undefined: no blink flop is built; all dicDsp* are constant 1.

Decomposition:
- Shared package: state encodings (3-bit localparams), MT_MAX=5, MO_MAX=9, ST_MAX=5, SO_MAX=9, saved-mode encodings.
- Sub-module dic_timeout_cnt: CNT_W counter with clear, tick_1s increment and terminal-count flag, parameterised by TIMEOUT_SEC.

Test Plan:
- Reset, then det_S, then det_cr -> dicRun 0 -> 1 -> 0; dicDsp* all 1 throughout.
- RUN, det_L, digits 2,3,4,9 -> dicRun=0 during the load; dicLdMtens/Mones/Stens/Sones each pulse 1 cycle after their digit with values 2,3,4,9; dicRun=1 after the last digit.
- STOP, det_L, digit 7 -> dicLdErr pulse, no strobe, stays in LD_MT; digit 5 -> dicLdMtens with value 5.
- STOP, det_L, one legal digit, then 10 tick_1s with no digit -> dicLdErr pulse on timeout, returns to STOP, dicRun=0.
- RUN, det_L, digit 1, det_cr and det_num asserted in the same cycle -> abort to RUN, no strobe; Mtens keeps 1.
- Load in progress, assert rst low mid-sequence -> state=STOP, outputs at reset values immediately, before any clk edge.
